regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Writeback stage directly upstream of `register_file`. Accepts result packets from two producers, the ALU and the load/store unit (LSU), through valid/ready handshakes. Buffers each producer's packets in a private FIFO and arbitrates round-robin between them. Drives the register file's single write port (`write_en`, `waddr`, `wdata`) from registered outputs, one write per cycle at most.

## Interface
- `DATA_WIDTH`, 64, width of write data; matches register file `wdata`.
- `ADDR_WIDTH`, 6, register address width; matches register file `waddr` (64 registers).
- `FIFO_DEPTH`, 4, entries per producer FIFO; power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result present.
- `alu_ready`  out  1  ALU FIFO can accept.
- `alu_waddr`  in  ADDR_WIDTH  ALU destination register.
- `alu_wdata`  in  DATA_WIDTH  ALU result.
- `mem_valid`  in  1  LSU result present.
- `mem_ready`  out  1  LSU FIFO can accept.
- `mem_waddr`  in  ADDR_WIDTH  LSU destination register.
- `mem_wdata`  in  DATA_WIDTH  LSU load data.
- `write_en`  out  1  to register file `write_en`.
- `waddr`  out  ADDR_WIDTH  to register file `waddr`.
- `wdata`  out  DATA_WIDTH  to register file `wdata`.
- `busy`  out  1  high when any FIFO is non-empty or `write_en` is high.

## Operation
- **Accept.** A packet is accepted at a rising edge when `x_valid && x_ready`. The packet `{x_waddr, x_wdata}` is pushed into that producer's FIFO.
- **Ready.** `x_ready` is `count_x < FIFO_DEPTH`, decoded from the count flop only. There is no combinational path from `valid` to `ready`, and no same-cycle pass-through when full.
- **Occupancy counter.** Each FIFO has `count_x` of width `$clog2(FIFO_DEPTH)+1`, plus read and write pointers of width `$clog2(FIFO_DEPTH)` that wrap modulo `FIFO_DEPTH`.
  - Push alone: count +1.
  - Pop alone: count −1.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- **Arbiter.** One `last_grant` flop (0 = ALU, 1 = LSU). Each cycle:
  - Neither FIFO has data: no grant, and `last_grant` holds.
  - Exactly one FIFO has data: that FIFO is granted.
  - Both FIFOs have data: the FIFO not named by `last_grant` is granted.
  - On any grant, the granted head is popped and `last_grant` is updated to the winner.
- **Write port.** On a grant cycle, at the edge `write_en` goes to 1 and `waddr`/`wdata` load the popped head. With no grant, `write_en` goes to 0 and `waddr`/`wdata` hold their last values.
- **Ordering.**
  - Packets from one producer reach the register file in acceptance order.
  - There is no ordering between producers. Upstream issue logic must not have two in-flight results to the same `waddr`; this block does not detect it.
- **Addresses.** Every address 0..63 is writable, including 0; there is no hardwired-zero register.

## Timing
- **Reset.** While `reset_n` is low, asynchronously: `write_en`=0, `waddr`=0, `wdata`=0, both counts and pointers =0, `last_grant`=1.
  - With `last_grant`=1, the ALU wins the first contested grant.
  - Outputs after reset release: `alu_ready`=1, `mem_ready`=1, `busy`=0.
  - FIFO storage arrays need no reset.
- **Latency.**
  - Packet accepted at edge N into an empty FIFO with no contention → `write_en`=1 with that packet after edge N+1.
  - The register file captures it at edge N+2.
- **Throughput.** One register write per cycle sustained. Each producer alone sustains one packet per cycle with `ready` held high.
- **Contention.** With both producers streaming, writes alternate ALU, LSU, ALU, … Each FIFO then drains at half rate, so `x_ready` deasserts once its FIFO fills.
- **Full.** At count = `FIFO_DEPTH`, `ready`=0. When a pop occurs at edge M, `ready` returns to 1 in the cycle after edge M.
- **Empty.** No pop and no `write_en` are produced from an empty FIFO; pointers never move on an empty pop.
- **Reset mid-operation.** All buffered packets are discarded. `write_en` drops to 0 immediately on `reset_n` falling, without waiting for a clock edge.

## Test plan
- **Reset values.** Hold `reset_n`=0 for 10 cycles → `write_en`=0, `waddr`=0, `wdata`=0, `alu_ready`=1, `mem_ready`=1, `busy`=0. After release and 5 idle cycles, all 64 register file entries read 0.
- **Single ALU write.** ALU packet `{waddr=6'h05, wdata=64'hDEAD_BEEF_0000_0005}` accepted at edge N → `write_en`=1, `waddr`=5, `wdata` matching after edge N+1. `write_en`=0 after edge N+2. RF[5] = `64'hDEAD_BEEF_0000_0005`.
- **Contention.** Both producers present one packet each in the same cycle (ALU → reg 1, LSU → reg 2) → writes to reg 1 then reg 2 in consecutive cycles. A second simultaneous pair (ALU → reg 3, LSU → reg 4) → reg 4 first, then reg 3.
- **Backpressure.** Both producers stream 8 packets each, with `valid` held high whenever `ready` is high → `alu_ready` drops while its FIFO holds 4 entries. All 16 writes appear, in per-producer order, with no duplicates or losses.
- **Wrap-around throughput.** LSU alone streams 10 packets to regs 10..19, one per cycle → `write_en` stays high for 10 consecutive cycles with `waddr` 10..19 in order. Pointers wrap twice without error.
- **Reset mid-operation.** Assert `reset_n`=0 with both FIFOs holding 3 entries and `write_en`=1 → `write_en`=0 before the next edge. After release `busy`=0 and no further writes occur.

Source files
------------

// File: rtl/regfile_writeback.sv
// Writeback stage: buffers ALU and LSU results in private FIFOs, arbitrates
// round-robin between them and drives the register file write port.
module regfile_writeback #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_waddr,
  input  logic [DATA_WIDTH-1:0] alu_wdata,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NPROD = 2;

  // One buffered result: destination register plus value.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } wb_pkt_t;

  // Producer index 0 is the ALU, index 1 is the LSU.
  logic [NPROD-1:0] valid_c;
  logic [NPROD-1:0] ready_c;
  logic [NPROD-1:0] push_c;
  logic [NPROD-1:0] has_c;
  logic [NPROD-1:0] grant_c;
  wb_pkt_t          in_pkt   [NPROD];
  wb_pkt_t          head_pkt [NPROD];
  wb_pkt_t          win_c;
  logic             last_grant;

  assign valid_c   = {mem_valid, alu_valid};
  assign in_pkt[0] = '{waddr: alu_waddr, wdata: alu_wdata};
  assign in_pkt[1] = '{waddr: mem_waddr, wdata: mem_wdata};

  assign alu_ready = ready_c[0];
  assign mem_ready = ready_c[1];

  for (genvar g = 0; g < NPROD; g++) begin : gen_fifo
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    wb_pkt_t          store [FIFO_DEPTH];

    // Ready and occupancy are decoded from the count flop only.
    assign ready_c[g]  = count < CNT_W'(FIFO_DEPTH);
    assign has_c[g]    = count != '0;
    assign push_c[g]   = valid_c[g] & ready_c[g];
    assign head_pkt[g] = store[rptr];

    // Occupancy counter and wrapping pointers; a pop only ever follows a grant.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        count <= '0;
        rptr  <= '0;
        wptr  <= '0;
      end else begin
        if (push_c[g]) begin
          wptr <= wptr + PTR_W'(1);
        end
        if (grant_c[g]) begin
          rptr <= rptr + PTR_W'(1);
        end
        if (push_c[g] && !grant_c[g]) begin
          count <= count + CNT_W'(1);
        end else if (!push_c[g] && grant_c[g]) begin
          count <= count - CNT_W'(1);
        end
      end
    end

    // Packet storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
      if (push_c[g]) begin
        store[wptr] <= in_pkt[g];
      end
    end
  end

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_c = '0;
    if (has_c[0] && has_c[1]) begin
      grant_c = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant_c = has_c;
    end
  end

  assign win_c = grant_c[1] ? head_pkt[1] : head_pkt[0];

  // Registered write port and arbiter history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_en   <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      last_grant <= 1'b1;
    end else if (|grant_c) begin
      write_en   <= 1'b1;
      waddr      <= win_c.waddr;
      wdata      <= win_c.wdata;
      last_grant <= grant_c[1];
    end else begin
      write_en   <= 1'b0;
    end
  end

  assign busy = (|has_c) | write_en;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: vector table plus hand-written
// sequences for backpressure, pointer wrap and reset during traffic.
module tb_regfile_writeback;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 6;

  localparam logic [63:0] Z  = 64'd0;
  localparam logic [63:0] A1 = 64'hA1A1_0000_0000_0001;
  localparam logic [63:0] B2 = 64'hB2B2_0000_0000_0002;
  localparam logic [63:0] A3 = 64'hA3A3_0000_0000_0003;
  localparam logic [63:0] B4 = 64'hB4B4_0000_0000_0004;
  localparam logic [63:0] D5 = 64'hDEAD_BEEF_0000_0005;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          alu_valid, alu_ready, mem_valid, mem_ready;
  logic [AW-1:0] alu_waddr, mem_waddr, waddr;
  logic [DW-1:0] alu_wdata, mem_wdata, wdata;
  logic          write_en, busy;

  regfile_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_waddr (alu_waddr),
    .alu_wdata (alu_wdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .write_en  (write_en),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Register file model and write log, sampled mid-cycle.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            c;
  } wr_t;
  wr_t           obs_q [$];
  logic [DW-1:0] rf [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && write_en) begin
      rf[waddr] = wdata;
      obs_q.push_back('{waddr, wdata, cyc});
    end
  end

  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          mv;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          ar;
    logic          mr;
    logic          bz;
  } vec_t;
  vec_t vt [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  int   ia, im, ka, km;
  logic acc_a, acc_m, saw_af, saw_mf, stall;
  logic all_zero;

  initial begin
    // idle-ALU/idle-LSU vectors use zeros for the don't-care payload
    vt[0]  = '{1'b1, 6'd1, A1, 1'b1, 6'd2, B2, 1'b0, 6'd0, Z,  1'b1, 1'b1, 1'b1};
    vt[1]  = '{1'b0, 6'd0, Z,  1'b0, 6'd0, Z,  1'b1, 6'd1, A1, 1'b1, 1'b1, 1'b1};
    vt[2]  = '{1'b0, 6'd0, Z,  1'b0, 6'd0, Z,  1'b1, 6'd2, B2, 1'b1, 1'b1, 1'b1};
    vt[3]  = '{1'b0, 6'd0, Z,  1'b0, 6'd0, Z,  1'b0, 6'd2, B2, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 6'd5, D5, 1'b0, 6'd0, Z,  1'b0, 6'd2, B2, 1'b1, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 6'd0, Z,  1'b0, 6'd0, Z,  1'b1, 6'd5, D5, 1'b1, 1'b1, 1'b1};
    vt[6]  = '{1'b0, 6'd0, Z,  1'b0, 6'd0, Z,  1'b0, 6'd5, D5, 1'b1, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 6'd3, A3, 1'b1, 6'd4, B4, 1'b0, 6'd5, D5, 1'b1, 1'b1, 1'b1};
    vt[8]  = '{1'b0, 6'd0, Z,  1'b0, 6'd0, Z,  1'b1, 6'd4, B4, 1'b1, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 6'd0, Z,  1'b0, 6'd0, Z,  1'b1, 6'd3, A3, 1'b1, 1'b1, 1'b1};
    vt[10] = '{1'b0, 6'd0, Z,  1'b0, 6'd0, Z,  1'b0, 6'd3, A3, 1'b1, 1'b1, 1'b0};

    for (int r = 0; r < 64; r++) rf[r] = '0;
    reset_n   = 1'b0;
    alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
    mem_valid = 1'b0; mem_waddr = '0; mem_wdata = '0;

    // Reset values
    repeat (10) @(posedge clk);
    #1;
    chk("rst_write_en",  64'(write_en),  64'd0);
    chk("rst_waddr",     64'(waddr),     64'd0);
    chk("rst_wdata",     wdata,          64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_mem_ready", 64'(mem_ready), 64'd1);
    chk("rst_busy",      64'(busy),      64'd0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    all_zero = 1'b1;
    for (int r = 0; r < 64; r++) if (rf[r] !== '0) all_zero = 1'b0;
    chk("rst_rf_zero",   64'(all_zero),     64'd1);
    chk("rst_no_writes", 64'(obs_q.size()), 64'd0);

    // Table: contention from reset, single ALU write, reversed contention
    for (int i = 0; i < 11; i++) begin
      alu_valid = vt[i].av; alu_waddr = vt[i].aa; alu_wdata = vt[i].ad;
      mem_valid = vt[i].mv; mem_waddr = vt[i].ma; mem_wdata = vt[i].md;
      @(posedge clk); #1;
      chk($sformatf("v%0d_write_en", i),  64'(write_en),  64'(vt[i].we));
      chk($sformatf("v%0d_waddr", i),     64'(waddr),     64'(vt[i].wa));
      chk($sformatf("v%0d_wdata", i),     wdata,          vt[i].wd);
      chk($sformatf("v%0d_alu_ready", i), 64'(alu_ready), 64'(vt[i].ar));
      chk($sformatf("v%0d_mem_ready", i), 64'(mem_ready), 64'(vt[i].mr));
      chk($sformatf("v%0d_busy", i),      64'(busy),      64'(vt[i].bz));
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("rf1", rf[1], A1);
    chk("rf2", rf[2], B2);
    chk("rf3", rf[3], A3);
    chk("rf4", rf[4], B4);
    chk("rf5", rf[5], D5);

    // Backpressure: both producers stream 8 packets with valid held high
    obs_q.delete();
    ia = 0; im = 0; saw_af = 1'b0; saw_mf = 1'b0;
    for (int c = 0; c < 100 && (ia < 8 || im < 8); c++) begin
      alu_valid = (ia < 8);
      alu_waddr = AW'(20 + ia);
      alu_wdata = {32'hA000_0000, 32'(ia)};
      mem_valid = (im < 8);
      mem_waddr = AW'(40 + im);
      mem_wdata = {32'hB000_0000, 32'(im)};
      acc_a = alu_valid && alu_ready;
      acc_m = mem_valid && mem_ready;
      if (!alu_ready) saw_af = 1'b1;
      if (!mem_ready) saw_mf = 1'b1;
      @(posedge clk); #1;
      if (acc_a) ia++;
      if (acc_m) im++;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("bp_accepted_alu", 64'(ia), 64'd8);
    chk("bp_accepted_mem", 64'(im), 64'd8);
    wait_idle("bp_drain", 60);
    chk("bp_alu_full_seen", 64'(saw_af), 64'd1);
    chk("bp_mem_full_seen", 64'(saw_mf), 64'd1);
    chk("bp_write_count", 64'(obs_q.size()), 64'd16);
    ka = 0; km = 0;
    foreach (obs_q[k]) begin
      if (obs_q[k].a >= AW'(40)) begin
        chk($sformatf("bp_mem%0d_addr", km), 64'(obs_q[k].a), 64'(40 + km));
        chk($sformatf("bp_mem%0d_data", km), obs_q[k].d, {32'hB000_0000, 32'(km)});
        km++;
      end else begin
        chk($sformatf("bp_alu%0d_addr", ka), 64'(obs_q[k].a), 64'(20 + ka));
        chk($sformatf("bp_alu%0d_data", ka), obs_q[k].d, {32'hA000_0000, 32'(ka)});
        ka++;
      end
    end

    // Wrap-around: LSU alone, one packet per cycle to regs 10..19
    obs_q.delete();
    stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      mem_valid = 1'b1;
      mem_waddr = AW'(10 + k);
      mem_wdata = {32'hC0DE_0000, 32'(k)};
      if (!mem_ready) stall = 1'b1;
      @(posedge clk); #1;
    end
    mem_valid = 1'b0;
    wait_idle("wrap_drain", 20);
    chk("wrap_no_stall", 64'(stall), 64'd0);
    chk("wrap_write_count", 64'(obs_q.size()), 64'd10);
    foreach (obs_q[k]) begin
      chk($sformatf("wrap%0d_addr", k), 64'(obs_q[k].a), 64'(10 + k));
      chk($sformatf("wrap%0d_data", k), obs_q[k].d, {32'hC0DE_0000, 32'(k)});
      chk($sformatf("wrap%0d_cycle", k), 64'(obs_q[k].c - obs_q[0].c), 64'(k));
    end

    // Reset mid-operation: both FIFOs hold 3 entries with a write in flight
    for (int k = 0; k < 5; k++) begin
      alu_valid = 1'b1; alu_waddr = AW'(50 + k); alu_wdata = 64'(k);
      mem_valid = 1'b1; mem_waddr = AW'(56 + k); mem_wdata = 64'(k);
      @(posedge clk); #1;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("mid_pre_write_en", 64'(write_en), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_write_en_async", 64'(write_en),  64'd0);
    chk("mid_busy_async",     64'(busy),      64'd0);
    chk("mid_waddr_async",    64'(waddr),     64'd0);
    chk("mid_alu_ready",      64'(alu_ready), 64'd1);
    obs_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_post_busy",   64'(busy),         64'd0);
    chk("mid_post_writes", 64'(obs_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
